// File: rtl/pong_frame_sequencer.sv
// pong_frame_sequencer: turns the per-frame pulse into a handshaked
// paddle/ball/collision step sequence and runs the match state machine.
// Optional feature macro: PONG_ATTRACT_MODE_EN (demo play while idle).
module pong_frame_sequencer #(
    parameter int unsigned FRAME_DIV    = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       start_btn,
    output logic       stage_req,
    output logic [1:0] stage_id,
    input  logic       stage_done,
    input  logic [1:0] edge_event,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_player,
    output logic [3:0] score_opp,
    output logic       game_over,
    output logic       winner,
    output logic       overrun
);
    localparam int unsigned DIV_W   = 4;
    localparam int unsigned SRV_W   = 8;
    localparam int unsigned SCORE_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_PLAY, S_STEP, S_POINT, S_OVER
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [SRV_W-1:0]   serve_cnt_q;
    logic [1:0]         stage_q;
    logic               stage_req_q;
    logic               pt_player_q;
    logic               ball_reset_q;
    logic               serve_dir_q;
    logic [SCORE_W-1:0] score_player_q;
    logic [SCORE_W-1:0] score_opp_q;
    logic               game_over_q;
    logic               winner_q;
    logic               overrun_q;

    logic               div_run_c;
    logic               tick_c;
    logic               attract_c;
    logic [SCORE_W-1:0] player_inc_c;
    logic [SCORE_W-1:0] opp_inc_c;

`ifdef PONG_ATTRACT_MODE_EN
    logic attract_q;
    assign attract_c = attract_q;
`else
    assign attract_c = 1'b0;
`endif

    // Frame divider runs during play and while a step sequence is in flight
    always_comb begin
        div_run_c = (state_q == S_PLAY) || (state_q == S_STEP) || (state_q == S_POINT);
`ifdef PONG_ATTRACT_MODE_EN
        if (state_q == S_IDLE) begin
            div_run_c = 1'b1;
        end
`endif
    end

    assign tick_c       = div_run_c && frame_start && (div_q == DIV_W'(FRAME_DIV - 1));
    assign player_inc_c = score_player_q + SCORE_W'(1);
    assign opp_inc_c    = score_opp_q + SCORE_W'(1);

    // Match FSM, divider, serve counter and step handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            div_q          <= '0;
            serve_cnt_q    <= '0;
            stage_q        <= 2'd0;
            stage_req_q    <= 1'b0;
            pt_player_q    <= 1'b0;
            ball_reset_q   <= 1'b1;
            serve_dir_q    <= 1'b1;
            score_player_q <= '0;
            score_opp_q    <= '0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef PONG_ATTRACT_MODE_EN
            attract_q      <= 1'b0;
`endif
        end else begin
            if (div_run_c && frame_start) begin
                div_q <= tick_c ? '0 : div_q + DIV_W'(1);
            end
            if (tick_c && ((state_q == S_STEP) || (state_q == S_POINT))) begin
                overrun_q <= 1'b1;
            end

            if (start_btn && ((state_q == S_IDLE) || (state_q == S_OVER))) begin
                state_q        <= S_SERVE;
                serve_cnt_q    <= '0;
                ball_reset_q   <= 1'b1;
                serve_dir_q    <= 1'b1;
                score_player_q <= '0;
                score_opp_q    <= '0;
                game_over_q    <= 1'b0;
                winner_q       <= 1'b0;
                overrun_q      <= 1'b0;
`ifdef PONG_ATTRACT_MODE_EN
                attract_q      <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
`ifdef PONG_ATTRACT_MODE_EN
                        ball_reset_q <= 1'b0;
                        if (tick_c) begin
                            state_q     <= S_STEP;
                            stage_q     <= 2'd0;
                            stage_req_q <= 1'b1;
                            attract_q   <= 1'b1;
                        end
`endif
                    end
                    S_SERVE: begin
                        if (frame_start) begin
                            if (serve_cnt_q == SRV_W'(SERVE_FRAMES - 1)) begin
                                state_q      <= S_PLAY;
                                serve_cnt_q  <= '0;
                                div_q        <= '0;
                                ball_reset_q <= 1'b0;
                            end else begin
                                serve_cnt_q <= serve_cnt_q + SRV_W'(1);
                            end
                        end
                    end
                    S_PLAY: begin
                        if (tick_c) begin
                            state_q     <= S_STEP;
                            stage_q     <= 2'd0;
                            stage_req_q <= 1'b1;
                        end
                    end
                    S_STEP: begin
                        if (!stage_req_q) begin
                            // one-cycle gap between stages is over
                            stage_req_q <= 1'b1;
                        end else if (stage_done) begin
                            stage_req_q <= 1'b0;
                            if (stage_q == 2'd2) begin
                                stage_q <= 2'd0;
                                if ((edge_event != 2'b00) && !attract_c) begin
                                    state_q     <= S_POINT;
                                    pt_player_q <= edge_event[0];
                                end else if (edge_event != 2'b00) begin
                                    // demo play: re-centre the ball, no scoring
                                    state_q      <= S_IDLE;
                                    ball_reset_q <= 1'b1;
                                    serve_dir_q  <= ~serve_dir_q;
                                end else begin
                                    state_q <= attract_c ? S_IDLE : S_PLAY;
                                end
                            end else begin
                                stage_q <= stage_q + 2'd1;
                            end
                        end
                    end
                    S_POINT: begin
                        ball_reset_q <= 1'b1;
                        serve_cnt_q  <= '0;
                        state_q      <= S_SERVE;
                        if (pt_player_q) begin
                            score_player_q <= player_inc_c;
                            serve_dir_q    <= 1'b0;
                            if (player_inc_c == SCORE_W'(WIN_SCORE)) begin
                                state_q     <= S_OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b1;
                            end
                        end else begin
                            score_opp_q <= opp_inc_c;
                            serve_dir_q <= 1'b1;
                            if (opp_inc_c == SCORE_W'(WIN_SCORE)) begin
                                state_q     <= S_OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b0;
                            end
                        end
                    end
                    S_OVER: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign stage_req    = stage_req_q;
    assign stage_id     = stage_q;
    assign ball_reset   = ball_reset_q;
    assign serve_dir    = serve_dir_q;
    assign score_player = score_player_q;
    assign score_opp    = score_opp_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// Testbench for pong_frame_sequencer: every change of the observed output
// vector is matched against a queue of expected vectors and cycle numbers.
module tb_pong_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b0;
    logic       stage_done = 1'b0;
    logic [1:0] edge_event = 2'b00;
    logic       stage_req;
    logic [1:0] stage_id;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_player;
    logic [3:0] score_opp;
    logic       game_over;
    logic       winner;
    logic       overrun;

    pong_frame_sequencer #(
        .FRAME_DIV   (2),
        .SERVE_FRAMES(3),
        .WIN_SCORE   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .start_btn   (start_btn),
        .stage_req   (stage_req),
        .stage_id    (stage_id),
        .stage_done  (stage_done),
        .edge_event  (edge_event),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .score_player(score_player),
        .score_opp   (score_opp),
        .game_over   (game_over),
        .winner      (winner),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // stage_id is only meaningful while stage_req is high, so it is masked
    typedef struct packed {
        logic       req;
        logic [1:0] id;
        logic       br;
        logic       sd;
        logic [3:0] sp;
        logic [3:0] so;
        logic       go;
        logic       win;
        logic       ov;
    } obs_t;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    obs_t  exp_obs[$];
    int    exp_cyc[$];
    string exp_nm[$];
    obs_t  mo;

    always @(posedge clk) cyc <= cyc + 1;

    // Unit responder: per-stage done latency, optional done while idle
    int         hold_cyc[4];
    bit         spur = 1'b0;
    logic [1:0] ev = 2'b00;
    int         wait_cnt = 0;
    always @(negedge clk) begin
        if (!stage_req) begin
            wait_cnt   = 0;
            stage_done = spur;
            edge_event = 2'b00;
        end else begin
            stage_done = (wait_cnt >= hold_cyc[stage_id]);
            wait_cnt   = wait_cnt + 1;
            edge_event = (stage_id == 2'd2) ? ev : 2'b00;
        end
    end

    // Monitor: compare each output change with the next expected entry
    obs_t  cur_obs;
    obs_t  prev_obs;
    obs_t  want_obs;
    int    want_cyc;
    string want_nm;
    bit    have_prev = 1'b0;
    always @(negedge clk) begin
        cur_obs.req = stage_req;
        cur_obs.id  = stage_req ? stage_id : 2'd0;
        cur_obs.br  = ball_reset;
        cur_obs.sd  = serve_dir;
        cur_obs.sp  = score_player;
        cur_obs.so  = score_opp;
        cur_obs.go  = game_over;
        cur_obs.win = winner;
        cur_obs.ov  = overrun;
        if (!have_prev || (cur_obs != prev_obs)) begin
            have_prev = 1'b1;
            prev_obs  = cur_obs;
            checks    = checks + 1;
            if (exp_obs.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_change: got obs=%h at cyc %0d, want no change", cur_obs, cyc);
            end else begin
                want_obs = exp_obs.pop_front();
                want_cyc = exp_cyc.pop_front();
                want_nm  = exp_nm.pop_front();
                if ((cur_obs !== want_obs) || (cyc != want_cyc)) begin
                    failures = failures + 1;
                    $display("FAIL %s: got obs=%h at cyc %0d, want obs=%h at cyc %0d",
                             want_nm, cur_obs, cyc, want_obs, want_cyc);
                end
            end
        end
    end

    function automatic obs_t reset_obs();
        obs_t o;
        o    = '0;
        o.br = 1'b1;
        o.sd = 1'b1;
        return o;
    endfunction

    task automatic push_exp(input string nm, input int d);
        exp_obs.push_back(mo);
        exp_cyc.push_back(cyc + d);
        exp_nm.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic press();
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    // Three frames in SERVE; ball released the cycle after the third
    task automatic serve3();
        frame(); idle(2);
        frame(); idle(2);
        mo.br = 1'b0;
        push_exp("serve_release", 1);
        frame(); idle(2);
    endtask

    // Stage transitions after a tick driven in the current cycle
    task automatic push_seq(input string tag, input int hold1);
        mo.req = 1'b1; mo.id = 2'd0; push_exp({tag, "_s0_req"}, 1);
        mo.req = 1'b0; mo.id = 2'd0; push_exp({tag, "_s0_gap"}, 2);
        mo.req = 1'b1; mo.id = 2'd1; push_exp({tag, "_s1_req"}, 3);
        mo.req = 1'b0; mo.id = 2'd0; push_exp({tag, "_s1_gap"}, 4 + hold1);
        mo.req = 1'b1; mo.id = 2'd2; push_exp({tag, "_s2_req"}, 5 + hold1);
        mo.req = 1'b0; mo.id = 2'd0; push_exp({tag, "_s2_end"}, 6 + hold1);
    endtask

    task automatic tick_go(input int hold1);
        frame();
        idle(9 + hold1);
    endtask

    initial begin
        hold_cyc[0] = 0; hold_cyc[1] = 0; hold_cyc[2] = 0; hold_cyc[3] = 0;
        mo = reset_obs();
        push_exp("reset_state", 1);
        idle(2);
        rst = 1'b0;
        idle(1);
        press(); idle(2);

        // zero-wait units, done held high throughout
        spur = 1'b1;
        serve3();
        frame(); idle(2);
        push_seq("zw", 0);
        tick_go(0);

        // stage 1 answers after 5 extra cycles
        hold_cyc[1] = 5;
        frame(); idle(2);
        push_seq("d5", 5);
        tick_go(5);
        hold_cyc[1] = 0;
        spur = 1'b0;

        // player point
        ev = 2'b01;
        frame(); idle(2);
        push_seq("pp1", 0);
        mo.br = 1'b1; mo.sd = 1'b0; mo.sp = 4'd1;
        push_exp("point_player1", 7);
        tick_go(0);
        serve3();

        // both edges: only player scores, reaching the win score
        ev = 2'b11;
        frame(); idle(2);
        push_seq("pp2", 0);
        mo.br = 1'b1; mo.sd = 1'b0; mo.sp = 4'd2; mo.go = 1'b1; mo.win = 1'b1;
        push_exp("win_player", 7);
        tick_go(0);
        repeat (4) begin frame(); idle(1); end

        mo.sd = 1'b1; mo.sp = 4'd0; mo.go = 1'b0; mo.win = 1'b0;
        push_exp("restart_after_player_win", 1);
        press(); idle(2);
        serve3();

        // opponent scores twice
        ev = 2'b10;
        frame(); idle(2);
        push_seq("po1", 0);
        mo.br = 1'b1; mo.sd = 1'b1; mo.so = 4'd1;
        push_exp("point_opp1", 7);
        tick_go(0);
        serve3();

        frame(); idle(2);
        push_seq("po2", 0);
        mo.br = 1'b1; mo.so = 4'd2; mo.go = 1'b1; mo.win = 1'b0;
        push_exp("win_opp", 7);
        tick_go(0);
        repeat (4) begin frame(); idle(1); end

        mo.so = 4'd0; mo.go = 1'b0;
        push_exp("restart_after_opp_win", 1);
        press(); idle(2);
        serve3();

        // stage 0 withheld across two ticks, then reset mid-handshake
        ev = 2'b00;
        hold_cyc[0] = 1000;
        frame(); idle(2);
        mo.req = 1'b1; mo.id = 2'd0;
        push_exp("ovr_s0_req", 1);
        frame(); idle(1);
        frame(); idle(1);
        mo.ov = 1'b1;
        push_exp("overrun_set", 1);
        frame(); idle(1);
        frame(); idle(1);
        frame(); idle(2);
        mo = reset_obs();
        push_exp("rst_mid_handshake", 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_cyc[0] = 0;

        // idle after reset is static; start then serves normally
        frame(); idle(2);
        frame(); idle(2);
        press(); idle(2);
        serve3();
        idle(5);

        while (exp_obs.size() > 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL %s: got no change, want obs=%h at cyc %0d",
                     exp_nm[0], exp_obs[0], exp_cyc[0]);
            void'(exp_obs.pop_front());
            void'(exp_cyc.pop_front());
            void'(exp_nm.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
